// File: rtl/elevator_motion_ctrl.sv
// Elevator car sequencer: accepts one floor request at a time, steps the car
// floor by floor using an external dest/floor comparator, then opens the door.
module elevator_motion_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [2:0] req_floor,
    output logic       req_ready,
    input  logic       dest_less,
    input  logic       dest_more,
    output logic [2:0] dest,
    output logic [2:0] floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       arrived,
    output logic       req_error
);

    localparam int MAXT = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW   = (MAXT < 2) ? 1 : $clog2(MAXT + 1);

    localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);
    localparam logic [2:0]    TOP_FLOOR  = 3'(NUM_FLOORS - 1);
    localparam logic [3:0]    NF         = 4'(NUM_FLOORS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR_OPEN
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    floor_q, floor_d;
    logic [2:0]    dest_q, dest_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dest_d  = dest_q;
        tick_d  = tick_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (req_valid && ready_q) begin
                    if ({1'b0, req_floor} < NF) begin
                        dest_d  = req_floor;
                        state_d = S_EVAL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EVAL: begin
                tick_d = '0;
                unique case ({dest_more, dest_less})
                    2'b10:   state_d = S_MOVE_UP;
                    2'b01:   state_d = S_MOVE_DOWN;
                    2'b00:   state_d = S_DOOR_OPEN;
                    default: begin
                        state_d = S_DOOR_OPEN;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_MOVE_UP: begin
                if (tick_q == FLOOR_LAST) begin
                    tick_d = '0;
                    // A car already at the top cannot climb; open the door in place.
                    if (floor_q == TOP_FLOOR) begin
                        state_d = S_DOOR_OPEN;
                    end else begin
                        floor_d = floor_q + 3'd1;
                        state_d = S_EVAL;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_MOVE_DOWN: begin
                if (tick_q == FLOOR_LAST) begin
                    tick_d = '0;
                    if (floor_q == 3'd0) begin
                        state_d = S_DOOR_OPEN;
                    end else begin
                        floor_d = floor_q - 3'd1;
                        state_d = S_EVAL;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_DOOR_OPEN: begin
                if (tick_q == DOOR_LAST) begin
                    tick_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                tick_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        // Ready is held low through reset and rises on the first edge after release.
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            floor_q <= 3'd0;
            dest_q  <= 3'd0;
            tick_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dest_q  <= dest_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready   = ready_q;
    assign dest        = dest_q;
    assign floor       = floor_q;
    assign moving_up   = (state_q == S_MOVE_UP);
    assign moving_down = (state_q == S_MOVE_DOWN);
    assign door_open   = (state_q == S_DOOR_OPEN);
    assign arrived     = (state_q == S_DOOR_OPEN) && (tick_q == '0);
    assign req_error   = err_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench for elevator_motion_ctrl: stimulus queues expected events
// (kind, floor, cycle); a negedge monitor pops and compares as the DUT produces them.
module tb_elevator_motion_ctrl;

    localparam int NF  = 6;
    localparam int FT  = 4;
    localparam int DT  = 3;
    localparam int STEP = FT + 1;

    localparam int EV_ERR   = 0;
    localparam int EV_FLOOR = 1;
    localparam int EV_UP    = 2;
    localparam int EV_DN    = 3;
    localparam int EV_ARR   = 4;
    localparam int EV_RDY   = 5;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_ready;
    logic       dest_less;
    logic       dest_more;
    logic [2:0] dest;
    logic [2:0] floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       arrived;
    logic       req_error;

    logic force_both;
    logic force_up;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  checks;
    int  failures;
    int  model_floor;

    logic       prev_up, prev_dn, prev_rdy;
    logic [2:0] prev_floor;

    elevator_motion_ctrl #(
        .NUM_FLOORS (NF),
        .FLOOR_TICKS(FT),
        .DOOR_TICKS (DT)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
        .req_ready  (req_ready),
        .dest_less  (dest_less),
        .dest_more  (dest_more),
        .dest       (dest),
        .floor      (floor),
        .moving_up  (moving_up),
        .moving_down(moving_down),
        .door_open  (door_open),
        .arrived    (arrived),
        .req_error  (req_error)
    );

    // Behavioural floor comparator with overrides for illegal / forced-up results.
    assign dest_less = force_both | (!force_up && (dest < floor));
    assign dest_more = force_both | force_up | (dest > floor);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, required no event",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                failures++;
                $display("FAIL event: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_up    = moving_up;
            prev_dn    = moving_down;
            prev_rdy   = 1'b1;
            prev_floor = floor;
        end else begin
            if (req_error)                 note(EV_ERR, int'(floor));
            if (floor != prev_floor)       note(EV_FLOOR, int'(floor));
            if (moving_up && !prev_up)     note(EV_UP, int'(floor));
            if (moving_down && !prev_dn)   note(EV_DN, int'(floor));
            if (arrived)                   note(EV_ARR, int'(floor));
            if (req_ready && !prev_rdy)    note(EV_RDY, int'(floor));
            prev_up    = moving_up;
            prev_dn    = moving_down;
            prev_rdy   = req_ready;
            prev_floor = floor;
        end
    end

    task automatic push_ev(input int kind, input int val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_trip(input int e0, input int s, input int t);
        int n;
        int d;
        n = (t > s) ? (t - s) : (s - t);
        d = (t > s) ? 1 : -1;
        for (int k = 0; k < n; k++) begin
            push_ev((d > 0) ? EV_UP : EV_DN, s + d * k, e0 + 1 + STEP * k);
            push_ev(EV_FLOOR, s + d * (k + 1), e0 + STEP * (k + 1));
        end
        push_ev(EV_ARR, t, e0 + STEP * n + 1);
        push_ev(EV_RDY, t, e0 + STEP * n + 1 + DT);
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            #2;
            i++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending events, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        int i;
        i = 0;
        while (cyc < target && i < 200) begin
            @(negedge clk);
            #2;
            i++;
        end
    endtask

    // Starts and ends at negedge+2 with the DUT idle.
    task automatic go(input int t);
        req_floor = 3'(t);
        req_valid = 1'b1;
        push_trip(cyc + 1, model_floor, t);
        @(posedge clk);
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        drain("trip", 300);
        model_floor = t;
    endtask

    task automatic reject(input int t);
        req_floor = 3'(t);
        req_valid = 1'b1;
        push_ev(EV_ERR, model_floor, cyc + 1);
        @(posedge clk);
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        drain("reject", 20);
        @(negedge clk);
        #2;
        chk("reject_dest", int'(dest), model_floor);
        chk("reject_ready", int'(req_ready), 1);
    endtask

    initial begin
        int e0;
        int e1;
        checks      = 0;
        failures    = 0;
        model_floor = 0;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_floor   = 3'd0;
        force_both  = 1'b0;
        force_up    = 1'b0;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_floor", int'(floor), 0);
        chk("rst_dest", int'(dest), 0);
        chk("rst_outs", int'({moving_up, moving_down, door_open, arrived, req_error}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        chk("post_rst_ready", int'(req_ready), 1);

        go(3);
        go(5);
        go(2);
        go(2);
        chk("same_floor", int'(floor), 2);

        reject(7);
        reject(6);

        // Request held through a move is only taken once the car is idle again.
        e0 = cyc + 1;
        e1 = e0 + STEP * 2 + 1 + DT + 1;
        push_trip(e0, 2, 4);
        push_trip(e1, 4, 0);
        req_floor = 3'd4;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        req_floor = 3'd0;
        wait_cyc(e1);
        req_valid = 1'b0;
        chk("held_accept_ready", int'(req_ready), 0);
        chk("held_accept_dest", int'(dest), 0);
        drain("held", 300);
        model_floor = 0;

        // Illegal comparator result in EVAL.
        e0 = cyc + 1;
        push_ev(EV_ERR, 0, e0 + 1);
        push_ev(EV_ARR, 0, e0 + 1);
        push_ev(EV_RDY, 0, e0 + 1 + DT);
        req_floor = 3'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        force_both = 1'b1;
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        force_both = 1'b0;
        drain("illegal", 20);
        chk("illegal_floor", int'(floor), 0);
        chk("illegal_dest", int'(dest), 3);

        // Top-floor guard: comparator forced to say "up" while already at the top.
        go(5);
        e0 = cyc + 1;
        push_ev(EV_UP, 5, e0 + 1);
        push_ev(EV_ARR, 5, e0 + FT + 1);
        push_ev(EV_RDY, 5, e0 + FT + 1 + DT);
        force_up  = 1'b1;
        req_floor = 3'd5;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        drain("guard", 30);
        force_up = 1'b0;
        chk("guard_floor", int'(floor), 5);

        // Asynchronous reset in the middle of a climb from floor 4.
        go(4);
        e0 = cyc + 1;
        push_ev(EV_UP, 4, e0 + 1);
        req_floor = 3'd5;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        wait_cyc(e0 + 3);
        chk("pre_rst_floor", int'(floor), 4);
        chk("pre_rst_up", int'(moving_up), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_floor", int'(floor), 0);
        chk("async_dest", int'(dest), 0);
        chk("async_outs", int'({req_ready, moving_up, moving_down, door_open, arrived, req_error}), 0);
        chk("async_queue", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        chk("rel_ready", int'(req_ready), 1);
        chk("rel_outs", int'({moving_up, moving_down, door_open, arrived, req_error}), 0);
        chk("rel_floor", int'(floor), 0);
        model_floor = 0;
        go(1);

        repeat (3) @(negedge clk);
        #2;
        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
